sad_line_matcher: RTL and testbench
===================================

Name: sad_line_matcher

Overview:
- Streaming 1-D SAD disparity core, successor to the fixed single-mode SAD stage of the stereo pipeline.
- Consumes column-aligned left/right mean-pixel pairs, one row at a time, from the image buffers.
- For each column, outputs the winning disparity, its cost and a confidence flag to the VGA buffer path.
- Parametrised in pixel width, line length, disparity range and window width; runtime-configurable search range and confidence threshold.

Parameters:
- PIX_W, 4, bits per mean pixel.
- LINE_W, 300, maximum columns per line.
- MAX_DISP, 16, number of candidate disparities, 0..MAX_DISP-1 (>=2).
- WIN, 5, horizontal window width in pixels (>=1).
- Derived widths (in package): DISP_W=clog2(MAX_DISP), CFG_W=clog2(MAX_DISP+1), SAD_W=clog2(WIN*DMAX+1), COL_W=clog2(LINE_W), where DMAX=2^PIX_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  input pair accepted when in_valid&&in_ready.
- in_left  in  PIX_W  left pixel, column x.
- in_right  in  PIX_W  right pixel, column x.
- in_sol  in  1  first column of a line.
- in_eol  in  1  last column of a line.
- cfg_max_disp  in  CFG_W  active search range, sampled on sol beat.
- cfg_thresh  in  SAD_W  confidence threshold.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_disp  out  DISP_W  winning disparity.
- out_cost  out  SAD_W  winning SAD cost.
- out_conf  out  1  out_cost <= cfg_thresh.
- out_eol  out  1  result belongs to the last column of a line.
- line_done  out  1  one-cycle pulse when the eol result is accepted.

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, rst.
- Reset values: all outputs 0 except in_ready=1. Reset clears all stage valids, pixel and cost histories, window sums and the column counter.
- Reset mid-line aborts the line; the next line must start with in_sol.
- Pipeline, 3 stages, all stepped by a common enable adv = !s3_valid || out_ready.
  - in_ready = adv.
  - Without stalls, a beat accepted at cycle t gives out_valid at t+3. Order is preserved and no result is dropped or duplicated.
  - If in_valid=0 while adv=1, a bubble enters; histories and sums do not update for a bubble.
- S1, absolute difference:
  - Column counter col is 0 on an sol beat, otherwise col+1, saturating at LINE_W-1.
  - Right-pixel shift register holds the previous MAX_DISP-1 right pixels.
  - d_k = |L[x]-R[x-k]| (PIX_W bits) for k=0..MAX_DISP-1.
  - If col < k, then d_k = DMAX (left border).
- S2, window sum per k: S_k = S_k + d_k(new) - d_k(oldest), using a WIN-deep history per k.
  - On an sol beat, the history is preloaded with DMAX and S_k = (WIN-1)*DMAX + d_k(new). The window never mixes lines.
  - Sums are exact in SAD_W bits; no saturation is needed.
- S3, argmin over k < eff_disp.
  - eff_disp = cfg_max_disp latched on the sol beat, with 0 treated as 1 and values >MAX_DISP clamped to MAX_DISP.
  - eff_disp is held for the whole line.
  - Ties: lowest k wins.
  - out_cost = winning S_k; out_conf = (out_cost <= cfg_thresh), with cfg_thresh sampled at the S3 register load.
- Results are column-trailing: out_disp for column x covers window x-WIN+1..x. Any centring offset is applied downstream.
- in_sol and in_eol on the same beat form a 1-column line and are legal.
- More than LINE_W beats without eol: col saturates, output continues and nothing else changes.
- Outputs are held stable while out_valid && !out_ready.
- line_done = out_valid && out_ready && out_eol, registered, one cycle.

Decomposition:
- Package sad_pkg holds:
  - the derived width localparams as functions of the parameters;
  - DMAX;
  - a typedef for the cost vector (array [MAX_DISP] of SAD_W);
  - a function abs_diff.
- Sub-module sad_argmin: masked minimum select over MAX_DISP costs, lowest-index tie-break, registered output. It forms S3.

Test Plan:
- Identity: L=R=x mod 16, 300 columns, MAX_DISP=16, WIN=5, cfg_max_disp=16 -> out_disp=0 for all x; out_cost=(4-x)*15 for x<4, 0 for x>=4; 300 results, last with out_eol and a line_done pulse.
- Shift 3: L[x]=R[x-3], L pseudo-random with distinct values -> out_disp=3 and out_cost=0 for every x>=7.
- Range limit: same stimulus, cfg_max_disp=2, cfg_thresh=0 -> out_disp in {0,1}, out_conf=0 for x>=7.
- Ties: L=R=7 constant, 50 columns -> out_disp=0, out_cost=0 for x>=4.
- Backpressure: out_ready pattern 1,0,1,0..., in_valid held high, shift-3 stimulus -> in_ready=0 exactly when out_valid&&!out_ready; result sequence identical to the unstalled run; no loss.
- Reset mid-line: rst pulsed at column 100 -> out_valid=0 and in_ready=1 immediately; a new sol line then reproduces the identity results exactly.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared widths, types and helpers for the streaming SAD line matcher.
// All sizing flows from the four base parameters below.
package sad_pkg;

  localparam int PIX_W    = 4;
  localparam int LINE_W   = 300;
  localparam int MAX_DISP = 16;
  localparam int WIN      = 5;

  localparam int DMAX   = (1 << PIX_W) - 1;
  localparam int DISP_W = $clog2(MAX_DISP);
  localparam int CFG_W  = $clog2(MAX_DISP + 1);
  localparam int SAD_W  = $clog2(WIN * DMAX + 1);
  localparam int COL_W  = $clog2(LINE_W);

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [SAD_W-1:0] sad_t;
  typedef logic [MAX_DISP-1:0][SAD_W-1:0] cost_vec_t;

  function automatic pix_t abs_diff(input pix_t a, input pix_t b);
    return (a >= b) ? pix_t'(a - b) : pix_t'(b - a);
  endfunction

  // A zero range still searches disparity 0; oversize ranges clamp to the array size.
  function automatic logic [CFG_W-1:0] clamp_disp(input logic [CFG_W-1:0] cfg);
    if (cfg == '0) return CFG_W'(1);
    if (cfg > CFG_W'(MAX_DISP)) return CFG_W'(MAX_DISP);
    return cfg;
  endfunction

endpackage

// File: rtl/sad_argmin.sv
// Final pipeline stage: masked minimum over the per-disparity window sums,
// lowest index wins ties, with the confidence compare folded into the load.
module sad_argmin
  import sad_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  cost_vec_t         costs,
  input  logic [CFG_W-1:0]  eff_disp,
  input  logic              in_eol,
  input  logic [SAD_W-1:0]  thresh,
  output logic              out_valid,
  output logic [DISP_W-1:0] out_disp,
  output logic [SAD_W-1:0]  out_cost,
  output logic              out_conf,
  output logic              out_eol
);

  logic [DISP_W-1:0] best_k;
  logic [SAD_W-1:0]  best_cost;

  logic              valid_q, valid_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [SAD_W-1:0]  cost_q, cost_d;
  logic              conf_q, conf_d;
  logic              eol_q, eol_d;

  // Candidate 0 is always in range, so it seeds the search; strict < keeps the lowest k on ties.
  always_comb begin
    best_k    = '0;
    best_cost = costs[0];
    for (int k = 1; k < MAX_DISP; k++) begin
      if ((k < int'(eff_disp)) && (costs[k] < best_cost)) begin
        best_k    = DISP_W'(k);
        best_cost = costs[k];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    disp_d  = disp_q;
    cost_d  = cost_q;
    conf_d  = conf_q;
    eol_d   = eol_q;
    if (en) begin
      valid_d = in_valid;
      if (in_valid) begin
        disp_d = best_k;
        cost_d = best_cost;
        conf_d = (best_cost <= thresh);
        eol_d  = in_eol;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      disp_q  <= '0;
      cost_q  <= '0;
      conf_q  <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      disp_q  <= disp_d;
      cost_q  <= cost_d;
      conf_q  <= conf_d;
      eol_q   <= eol_d;
    end
  end

  assign out_valid = valid_q;
  assign out_disp  = disp_q;
  assign out_cost  = cost_q;
  assign out_conf  = conf_q;
  assign out_eol   = eol_q;

endmodule

// File: rtl/sad_line_matcher.sv
// Streaming 1-D SAD disparity core: per-disparity absolute differences, running
// WIN-wide window sums, then a masked argmin; all three stages share one enable.
module sad_line_matcher
  import sad_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_left,
  input  logic [PIX_W-1:0]  in_right,
  input  logic              in_sol,
  input  logic              in_eol,
  input  logic [CFG_W-1:0]  cfg_max_disp,
  input  logic [SAD_W-1:0]  cfg_thresh,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DISP_W-1:0] out_disp,
  output logic [SAD_W-1:0]  out_cost,
  output logic              out_conf,
  output logic              out_eol,
  output logic              line_done
);

  typedef logic [MAX_DISP-1:0][PIX_W-1:0]          diff_vec_t;
  typedef logic [MAX_DISP-1:0][WIN-1:0][PIX_W-1:0] win_hist_t;

  logic adv;
  logic accept;

  logic [COL_W-1:0]               col_q, col_d, col_now;
  logic [CFG_W-1:0]               line_disp_q, line_disp_d, eff_now;
  logic [MAX_DISP-2:0][PIX_W-1:0] rhist_q, rhist_d;
  diff_vec_t                      rwin, diff_now;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sol_q, s1_sol_d;
  logic             s1_eol_q, s1_eol_d;
  logic [CFG_W-1:0] s1_eff_q, s1_eff_d;
  diff_vec_t        s1_diff_q, s1_diff_d;

  win_hist_t        whist_q, whist_d;
  cost_vec_t        sum_q, sum_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_eol_q, s2_eol_d;
  logic [CFG_W-1:0] s2_eff_q, s2_eff_d;

  logic line_done_q, line_done_d;

  // rwin[k] is R[x-k]; a column left of k has no partner and costs DMAX.
  always_comb begin
    adv      = !out_valid || out_ready;
    accept   = in_valid && adv;
    rwin     = {rhist_q, in_right};
    eff_now  = in_sol ? clamp_disp(cfg_max_disp) : line_disp_q;

    if (in_sol)
      col_now = '0;
    else if (col_q == COL_W'(LINE_W - 1))
      col_now = col_q;
    else
      col_now = col_q + 1'b1;

    diff_now = '0;
    for (int k = 0; k < MAX_DISP; k++)
      diff_now[k] = (int'(col_now) < k) ? '1 : abs_diff(in_left, rwin[k]);

    col_d       = col_q;
    line_disp_d = line_disp_q;
    rhist_d     = rhist_q;
    s1_valid_d  = s1_valid_q;
    s1_sol_d    = s1_sol_q;
    s1_eol_d    = s1_eol_q;
    s1_eff_d    = s1_eff_q;
    s1_diff_d   = s1_diff_q;

    if (adv)
      s1_valid_d = in_valid;
    if (accept) begin
      col_d       = col_now;
      line_disp_d = eff_now;
      rhist_d     = rwin[MAX_DISP-2:0];
      s1_sol_d    = in_sol;
      s1_eol_d    = in_eol;
      s1_eff_d    = eff_now;
      s1_diff_d   = diff_now;
    end
  end

  // A line start refills the window with DMAX so sums never straddle two lines.
  always_comb begin
    whist_d    = whist_q;
    sum_d      = sum_q;
    s2_valid_d = s2_valid_q;
    s2_eol_d   = s2_eol_q;
    s2_eff_d   = s2_eff_q;

    if (adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_eol_d = s1_eol_q;
        s2_eff_d = s1_eff_q;
        for (int k = 0; k < MAX_DISP; k++) begin
          if (s1_sol_q) begin
            whist_d[k] = '1;
            sum_d[k]   = SAD_W'((WIN - 1) * DMAX) + SAD_W'(s1_diff_q[k]);
          end else begin
            for (int w = WIN - 1; w > 0; w--)
              whist_d[k][w] = whist_q[k][w-1];
            sum_d[k] = sum_q[k] + SAD_W'(s1_diff_q[k]) - SAD_W'(whist_q[k][WIN-1]);
          end
          whist_d[k][0] = s1_diff_q[k];
        end
      end
    end
  end

  always_comb begin
    line_done_d = out_valid && out_ready && out_eol;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      line_disp_q <= '0;
      rhist_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_sol_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s1_eff_q    <= '0;
      s1_diff_q   <= '0;
      whist_q     <= '0;
      sum_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_eol_q    <= 1'b0;
      s2_eff_q    <= '0;
      line_done_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      line_disp_q <= line_disp_d;
      rhist_q     <= rhist_d;
      s1_valid_q  <= s1_valid_d;
      s1_sol_q    <= s1_sol_d;
      s1_eol_q    <= s1_eol_d;
      s1_eff_q    <= s1_eff_d;
      s1_diff_q   <= s1_diff_d;
      whist_q     <= whist_d;
      sum_q       <= sum_d;
      s2_valid_q  <= s2_valid_d;
      s2_eol_q    <= s2_eol_d;
      s2_eff_q    <= s2_eff_d;
      line_done_q <= line_done_d;
    end
  end

  sad_argmin u_argmin (
    .clk       (clk),
    .rst       (rst),
    .en        (adv),
    .in_valid  (s2_valid_q),
    .costs     (sum_q),
    .eff_disp  (s2_eff_q),
    .in_eol    (s2_eol_q),
    .thresh    (cfg_thresh),
    .out_valid (out_valid),
    .out_disp  (out_disp),
    .out_cost  (out_cost),
    .out_conf  (out_conf),
    .out_eol   (out_eol)
  );

  assign in_ready  = adv;
  assign line_done = line_done_q;

endmodule

// File: tb/tb_sad_line_matcher.sv
// Self-checking bench for sad_line_matcher: directed and randomized lines are
// scored against a window-sum reference computed directly from pixel arrays.
module tb_sad_line_matcher;
  import sad_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PIX_W-1:0]  in_left = '0;
  logic [PIX_W-1:0]  in_right = '0;
  logic              in_sol = 1'b0;
  logic              in_eol = 1'b0;
  logic [CFG_W-1:0]  cfg_max_disp = '0;
  logic [SAD_W-1:0]  cfg_thresh = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DISP_W-1:0] out_disp;
  logic [SAD_W-1:0]  out_cost;
  logic              out_conf;
  logic              out_eol;
  logic              line_done;

  typedef struct {
    int disp;
    int cost;
    int conf;
    int eol;
  } exp_t;

  exp_t exp_q[$];
  int   line_l[LINE_W];
  int   line_r[LINE_W];
  int   cur_eff = 1;
  int   cur_thresh = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   ready_mode = 0;
  int   bubble_pct = 0;
  bit   prev_fire = 1'b0;

  sad_line_matcher dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_left      (in_left),
    .in_right     (in_right),
    .in_sol       (in_sol),
    .in_eol       (in_eol),
    .cfg_max_disp (cfg_max_disp),
    .cfg_thresh   (cfg_thresh),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_disp     (out_disp),
    .out_cost     (out_cost),
    .out_conf     (out_conf),
    .out_eol      (out_eol),
    .line_done    (line_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // SAD of the WIN columns ending at x for disparity k; columns before the line or left of k count DMAX.
  function automatic int refCost(input int x, input int k);
    int s = 0;
    for (int i = x - WIN + 1; i <= x; i++) begin
      if (i < k) s += DMAX;
      else if (line_l[i] >= line_r[i-k]) s += line_l[i] - line_r[i-k];
      else s += line_r[i-k] - line_l[i];
    end
    return s;
  endfunction

  task automatic pushExpected(input int x, input bit eol);
    exp_t e;
    int   c;
    e.disp = 0;
    e.cost = refCost(x, 0);
    for (int k = 1; k < cur_eff; k++) begin
      c = refCost(x, k);
      if (c < e.cost) begin
        e.cost = c;
        e.disp = k;
      end
    end
    e.conf = (e.cost <= cur_thresh) ? 1 : 0;
    e.eol  = eol ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Drives one column and waits (bounded) for the handshake, sampling in_ready mid-cycle.
  task automatic applyStimulus(input int x, input bit sol, input bit eol);
    bit acc;
    int guard;
    if (bubble_pct > 0 && $urandom_range(99) < bubble_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_left  = PIX_W'(line_l[x]);
    in_right = PIX_W'(line_r[x]);
    in_sol   = sol;
    in_eol   = eol;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("accept", acc, 1);
    if (acc) pushExpected(x, eol);
  endtask

  // kind: 0 identity, 1 shift-by-3, 2 constant 7, 3 random pixels.
  task automatic runLine(input int kind, input int len, input int cfg, input int thresh, input int beats);
    for (int x = 0; x < len; x++) begin
      case (kind)
        0: begin line_l[x] = x % 16; line_r[x] = x % 16; end
        1: begin
             line_r[x] = int'($urandom_range(DMAX));
             line_l[x] = (x >= 3) ? line_r[x-3] : int'($urandom_range(DMAX));
           end
        2: begin line_l[x] = 7; line_r[x] = 7; end
        default: begin
             line_l[x] = int'($urandom_range(DMAX));
             line_r[x] = int'($urandom_range(DMAX));
           end
      endcase
    end
    cfg_max_disp = CFG_W'(cfg);
    cfg_thresh   = SAD_W'(thresh);
    cur_eff      = (cfg == 0) ? 1 : ((cfg > MAX_DISP) ? MAX_DISP : cfg);
    cur_thresh   = thresh;
    for (int x = 0; x < beats; x++)
      applyStimulus(x, x == 0, x == len - 1);
    in_valid = 1'b0;
    in_sol   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk); #2;
      guard++;
    end
    checkOutput("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Downstream ready pattern: always, alternating, or random.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Result scoreboard, handshake rule and line_done pulse, all sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_fire = 1'b0;
      end else begin
        checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
        checkOutput("line_done", line_done, prev_fire);
        if (out_valid && out_ready) begin
          checkOutput("pending_results", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("out_disp", out_disp, e.disp);
            checkOutput("out_cost", out_cost, e.cost);
            checkOutput("out_conf", out_conf, e.conf);
            checkOutput("out_eol", out_eol, e.eol);
          end
        end
        prev_fire = out_valid && out_ready && out_eol;
      end
    end
  end

  initial begin
    int len;
    int kind;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_line_done", line_done, 0);
    checkOutput("reset_out_disp", out_disp, 0);
    checkOutput("reset_out_cost", out_cost, 0);
    checkOutput("reset_out_conf", out_conf, 0);
    checkOutput("reset_out_eol", out_eol, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] identity line, 300 columns");
    runLine(0, 300, 16, 20, 300);
    waitDrain();

    $display("[TB] shift-3 line");
    runLine(1, 60, 16, 0, 60);
    waitDrain();

    $display("[TB] shift-3 line with range limited to 2");
    runLine(1, 60, 2, 0, 60);
    waitDrain();

    $display("[TB] constant-7 tie line");
    runLine(2, 50, 16, 0, 50);
    waitDrain();

    $display("[TB] alternating backpressure");
    ready_mode = 1;
    runLine(1, 60, 16, 10, 60);
    waitDrain();
    ready_mode = 0;

    $display("[TB] reset in the middle of a line");
    runLine(0, 300, 16, 20, 100);
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    runLine(0, 300, 16, 20, 300);
    waitDrain();

    $display("[TB] one-column lines");
    runLine(3, 1, 16, 70, 1);
    runLine(3, 1, 0, 70, 1);
    waitDrain();

    $display("[TB] randomized lines with bubbles and random backpressure");
    ready_mode = 2;
    bubble_pct = 25;
    cfg_thresh = SAD_W'($urandom_range(40));
    for (int n = 0; n < 10; n++) begin
      len  = int'($urandom_range(40, 1));
      kind = ($urandom_range(1) == 0) ? 1 : 3;
      runLine(kind, len, int'($urandom_range((1 << CFG_W) - 1)), int'(cfg_thresh), len);
    end
    waitDrain();
    ready_mode = 0;
    bubble_pct = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
